// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port, synchronous-read, write-first data memory between
//   an instruction-fetch requester (port 0, read-only) and a load/store
//   requester (port 1, read/write). Simultaneous requests are resolved
//   round-robin. A built-in sequencer zeroes the whole memory on command.
//   This block is the only driver of the memory's address, wf and w inputs.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   p0_req/p0_addr     port 0 read request (held until granted) and address
//   p0_gnt             port 0 accepted at the coming rising edge
//   p0_rvalid/p0_rdata port 0 read data, valid one cycle after the grant
//   p1_req/p1_we       port 1 request (held until granted), write(1)/read(0)
//   p1_addr/p1_wdata   port 1 address and write data
//   p1_gnt             port 1 accepted at the coming rising edge
//   p1_rvalid/p1_rdata port 1 read data, valid one cycle after a read grant
//   clr_req            pulse: start a whole-memory clear
//   clr_busy           clear in progress (exactly 2^M cycles)
//   clr_done           one-cycle pulse when the clear finishes
//   mem_address/wf/w   memory address, write flag and write value
//   mem_v              memory read value
module mem_arbiter #(
  parameter int N = 32,
  parameter int M = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         p0_req,
  input  logic [M-1:0] p0_addr,
  output logic         p0_gnt,
  output logic         p0_rvalid,
  output logic [N-1:0] p0_rdata,
  input  logic         p1_req,
  input  logic         p1_we,
  input  logic [M-1:0] p1_addr,
  input  logic [N-1:0] p1_wdata,
  output logic         p1_gnt,
  output logic         p1_rvalid,
  output logic [N-1:0] p1_rdata,
  input  logic         clr_req,
  output logic         clr_busy,
  output logic         clr_done,
  output logic [M-1:0] mem_address,
  output logic         mem_wf,
  output logic [N-1:0] mem_w,
  input  logic [N-1:0] mem_v
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // True when the clear counter points at the final memory entry.
  function automatic logic is_last_addr(input logic [M-1:0] addr);
    return (addr == {M{1'b1}});
  endfunction

  state_t       state_r;
  state_t       state_next_s;
  logic         ptr_r;        // 0: port 0 wins the next tie, 1: port 1 wins
  logic         ptr_next_s;
  logic [M-1:0] cnt_r;
  logic [M-1:0] cnt_next_s;
  logic         gnt0_s;
  logic         gnt1_s;
  logic         p0_rvalid_r;
  logic         p1_rvalid_r;
  logic         clr_done_r;

  // Next-state, round-robin grant and clear-counter logic.
  always_comb begin
    state_next_s = state_r;
    ptr_next_s   = ptr_r;
    cnt_next_s   = cnt_r;
    gnt0_s       = 1'b0;
    gnt1_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rst) begin
          // Grants are held off while reset is asserted.
          state_next_s = IDLE;
        end else if (clr_req) begin
          // A clear command outranks both ports in the cycle it is seen.
          state_next_s = CLEAR;
          cnt_next_s   = {M{1'b0}};
        end else if (p0_req && p1_req) begin
          if (ptr_r == 1'b0) begin
            gnt0_s = 1'b1;
          end else begin
            gnt1_s = 1'b1;
          end
          // Only a contested grant hands priority to the other port.
          ptr_next_s = ~ptr_r;
        end else if (p0_req) begin
          gnt0_s = 1'b1;
        end else if (p1_req) begin
          gnt1_s = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      CLEAR: begin
        cnt_next_s = cnt_r + {{(M-1){1'b0}}, 1'b1};
        if (is_last_addr(cnt_r)) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = CLEAR;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Memory-side drive: clear writes, else the granted port, else all zero.
  always_comb begin
    mem_address = {M{1'b0}};
    mem_wf      = 1'b0;
    mem_w       = {N{1'b0}};
    if (state_r == CLEAR) begin
      mem_address = cnt_r;
      mem_wf      = 1'b1;
      mem_w       = {N{1'b0}};
    end else if (gnt0_s) begin
      mem_address = p0_addr;
      mem_wf      = 1'b0;
    end else if (gnt1_s) begin
      mem_address = p1_addr;
      mem_wf      = p1_we;
      mem_w       = p1_wdata;
    end else begin
      mem_address = {M{1'b0}};
    end
  end

  // State, priority pointer, clear counter and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      ptr_r       <= 1'b0;
      cnt_r       <= {M{1'b0}};
      p0_rvalid_r <= 1'b0;
      p1_rvalid_r <= 1'b0;
      clr_done_r  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      ptr_r       <= ptr_next_s;
      cnt_r       <= cnt_next_s;
      // The memory returns data one cycle after the address is presented.
      p0_rvalid_r <= gnt0_s;
      p1_rvalid_r <= gnt1_s & ~p1_we;
      clr_done_r  <= (state_r == CLEAR) && is_last_addr(cnt_r);
    end
  end

  assign p0_gnt    = gnt0_s;
  assign p1_gnt    = gnt1_s;
  assign p0_rvalid = p0_rvalid_r;
  assign p1_rvalid = p1_rvalid_r;
  assign p0_rdata  = mem_v;
  assign p1_rdata  = mem_v;
  assign clr_busy  = (state_r == CLEAR);
  assign clr_done  = clr_done_r;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       p0_req;
  logic [3:0] p0_addr;
  logic       p0_gnt;
  logic       p0_rvalid;
  logic [7:0] p0_rdata;
  logic       p1_req;
  logic       p1_we;
  logic [3:0] p1_addr;
  logic [7:0] p1_wdata;
  logic       p1_gnt;
  logic       p1_rvalid;
  logic [7:0] p1_rdata;
  logic       clr_req;
  logic       clr_busy;
  logic       clr_done;
  logic [3:0] mem_address;
  logic       mem_wf;
  logic [7:0] mem_w;
  logic [7:0] mem_v;

  always #5 clk = ~clk;

  mem_arbiter #(.N(8), .M(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_address(mem_address), .mem_wf(mem_wf), .mem_w(mem_w), .mem_v(mem_v)
  );

  // Memory instance: single port, synchronous read, write-first.
  logic [7:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (mem_wf) begin
      mem[mem_address] <= mem_w;
      mem_v            <= mem_w;
    end else begin
      mem_v <= mem[mem_address];
    end
  end

  int n_pass = 0;
  int n_total = 0;

  // Reference model: contents, clear progress, which port wins a tie,
  // and the read results owed to each port next cycle.
  logic [7:0] ref_mem [16];
  bit         m_clearing;
  int         m_cnt;
  int         m_ptr;
  bit         m_done;
  bit         m_pend0, m_pend1;
  logic [7:0] m_d0, m_d1;

  // Values sampled in the most recent cycle.
  logic       s_g0, s_g1, s_rv0, s_rv1, s_busy, s_done, s_wf;
  logic [7:0] s_rd0, s_rd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_clearing = 1'b0;
    m_cnt      = 0;
    m_ptr      = 0;
    m_done     = 1'b0;
    m_pend0    = 1'b0;
    m_pend1    = 1'b0;
  endtask

  // One clock cycle: inputs already applied; compare at the falling edge,
  // advance the model, return 1 time unit after the next rising edge.
  task automatic cycle();
    int win;
    @(negedge clk);
    win = -1;
    if (rst !== 1'b0 && !m_clearing && !clr_req) begin
      if (p0_req && p1_req) win = m_ptr;
      else if (p0_req) win = 0;
      else if (p1_req) win = 1;
    end
    s_g0 = p0_gnt; s_g1 = p1_gnt; s_rv0 = p0_rvalid; s_rv1 = p1_rvalid;
    s_rd0 = p0_rdata; s_rd1 = p1_rdata; s_busy = clr_busy; s_done = clr_done;
    s_wf = mem_wf;
    check("p0_gnt", 32'(p0_gnt), 32'(win == 0));
    check("p1_gnt", 32'(p1_gnt), 32'(win == 1));
    check("p0_rvalid", 32'(p0_rvalid), 32'(m_pend0));
    check("p1_rvalid", 32'(p1_rvalid), 32'(m_pend1));
    if (m_pend0) check("p0_rdata", 32'(p0_rdata), 32'(m_d0));
    if (m_pend1) check("p1_rdata", 32'(p1_rdata), 32'(m_d1));
    check("clr_busy", 32'(clr_busy), 32'(m_clearing));
    check("clr_done", 32'(clr_done), 32'(m_done));
    if (m_clearing) begin
      check("clr_addr", 32'(mem_address), 32'(m_cnt));
      check("clr_wf", 32'(mem_wf), 32'd1);
      check("clr_w", 32'(mem_w), 32'd0);
    end else if (win == 0) begin
      check("p0_addr_out", 32'(mem_address), 32'(p0_addr));
      check("p0_wf", 32'(mem_wf), 32'd0);
    end else if (win == 1) begin
      check("p1_addr_out", 32'(mem_address), 32'(p1_addr));
      check("p1_wf", 32'(mem_wf), 32'(p1_we));
      check("p1_w", 32'(mem_w), 32'(p1_wdata));
    end else begin
      check("idle_addr", 32'(mem_address), 32'd0);
      check("idle_wf", 32'(mem_wf), 32'd0);
      check("idle_w", 32'(mem_w), 32'd0);
    end
    if (rst === 1'b0) begin
      model_reset();
    end else begin
      m_done  = m_clearing && (m_cnt == 15);
      m_pend0 = (win == 0);
      m_d0    = ref_mem[p0_addr];
      m_pend1 = (win == 1) && !p1_we;
      m_d1    = ref_mem[p1_addr];
      if (win == 1 && p1_we) ref_mem[p1_addr] = p1_wdata;
      if (m_clearing) begin
        ref_mem[m_cnt] = 8'h00;
        m_cnt++;
        if (m_cnt == 16) begin
          m_clearing = 1'b0;
          m_cnt      = 0;
        end
      end else if (clr_req && rst) begin
        m_clearing = 1'b1;
        m_cnt      = 0;
      end
      if (p0_req && p1_req && win >= 0) m_ptr = 1 - win;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic p0r; logic [3:0] p0a;
    logic p1r; logic p1w; logic [3:0] p1a; logic [7:0] p1d;
    logic g0; logic g1; logic rv0; logic rv1; logic [7:0] d0; logic [7:0] d1;
  } vec_t;
  vec_t vt [13];

  int busy_n, done_n, gnt_busy_n, gnt_done_n;

  initial begin
    // Directed vectors: write/read, contested reads, write-then-read.
    vt[0]  = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[1]  = '{1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[2]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h00};
    vt[3]  = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[4]  = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[5]  = '{1'b1, 4'd1, 1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[6]  = '{1'b1, 4'd1, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 8'h00};
    vt[7]  = '{1'b1, 4'd1, 1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h22};
    vt[8]  = '{1'b1, 4'd1, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 8'h00};
    vt[9]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h22};
    vt[10] = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[11] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[12] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h3C};

    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    model_reset();

    // Reset state, with both ports requesting.
    rst = 1'b0; clr_req = 1'b0;
    p0_req = 1'b1; p0_addr = 4'd0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 4'd0; p1_wdata = 8'h00;
    @(posedge clk); #1;
    check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    check("rst_p1_gnt", 32'(p1_gnt), 32'd0);
    check("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
    check("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
    check("rst_clr_busy", 32'(clr_busy), 32'd0);
    check("rst_clr_done", 32'(clr_done), 32'd0);
    p0_req = 1'b0; p1_req = 1'b0;
    rst = 1'b1;
    cycle();

    for (int i = 0; i < 13; i++) begin
      p0_req = vt[i].p0r; p0_addr = vt[i].p0a;
      p1_req = vt[i].p1r; p1_we = vt[i].p1w; p1_addr = vt[i].p1a; p1_wdata = vt[i].p1d;
      cycle();
      check("tbl_g0", 32'(s_g0), 32'(vt[i].g0));
      check("tbl_g1", 32'(s_g1), 32'(vt[i].g1));
      check("tbl_rv0", 32'(s_rv0), 32'(vt[i].rv0));
      check("tbl_rv1", 32'(s_rv1), 32'(vt[i].rv1));
      if (vt[i].rv0) check("tbl_rd0", 32'(s_rd0), 32'(vt[i].d0));
      if (vt[i].rv1) check("tbl_rd1", 32'(s_rd1), 32'(vt[i].d1));
    end

    // Withdrawn write: p1 loses a tie to p0, then drops its request.
    p0_req = 1'b1; p0_addr = 4'd1;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 4'd7; p1_wdata = 8'h77;
    cycle();
    check("wd_tie_g0", 32'(s_g0), 32'd1);
    check("wd_tie_g1", 32'(s_g1), 32'd0);
    p1_req = 1'b0; p0_addr = 4'd2;
    cycle();
    check("wd_drop_g1", 32'(s_g1), 32'd0);
    check("wd_no_write", 32'(s_wf), 32'd0);
    // The tie handed priority to p1; the withdrawal changed nothing further.
    p0_addr = 4'd1; p1_req = 1'b1; p1_we = 1'b0; p1_addr = 4'd7;
    cycle();
    check("wd_next_tie_g1", 32'(s_g1), 32'd1);
    p1_req = 1'b0;
    cycle();
    check("wd_p0_after", 32'(s_g0), 32'd1);
    check("wd_rd7_valid", 32'(s_rv1), 32'd1);
    check("wd_rd7_unwritten", 32'(s_rd1), 32'd0);
    p0_req = 1'b0;
    cycle();

    // Clear: fill memory, then clear while p0 waits.
    for (int a = 0; a < 16; a++) begin
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 4'(a); p1_wdata = 8'($urandom_range(1, 255));
      cycle();
    end
    p1_req = 1'b0;
    p0_req = 1'b1; p0_addr = 4'd4; clr_req = 1'b1;
    cycle();
    check("clr_req_blocks_gnt", 32'(s_g0), 32'd0);
    clr_req = 1'b0;
    busy_n = 0; done_n = 0; gnt_busy_n = 0; gnt_done_n = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (s_busy) busy_n++;
      if (s_busy && s_g0) gnt_busy_n++;
      if (s_done) begin
        done_n++;
        if (s_g0) gnt_done_n++;
      end
      if (s_g0) p0_req = 1'b0;
    end
    check("clr_busy_cycles", 32'(busy_n), 32'd16);
    check("clr_done_pulses", 32'(done_n), 32'd1);
    check("clr_no_gnt_busy", 32'(gnt_busy_n), 32'd0);
    check("clr_gnt_in_done", 32'(gnt_done_n), 32'd1);
    for (int a = 0; a <= 16; a++) begin
      p0_req = (a < 16); p0_addr = 4'(a);
      cycle();
      if (a > 0) begin
        check("clr_rd_valid", 32'(s_rv0), 32'd1);
        check("clr_rd_zero", 32'(s_rd0), 32'd0);
      end
    end
    p0_req = 1'b0;

    // Re-trigger during clear is ignored.
    clr_req = 1'b1;
    cycle();
    busy_n = 0; done_n = 0;
    for (int k = 0; k < 20; k++) begin
      clr_req = (k == 5);
      cycle();
      if (s_busy) busy_n++;
      if (s_done) done_n++;
    end
    clr_req = 1'b0;
    check("retrig_busy_cycles", 32'(busy_n), 32'd16);
    check("retrig_done_pulses", 32'(done_n), 32'd1);

    // Reset aborts a clear in progress.
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int k = 0; k < 8; k++) cycle();
    rst = 1'b0;
    #1;
    check("abort_busy_now", 32'(clr_busy), 32'd0);
    check("abort_wf_now", 32'(mem_wf), 32'd0);
    model_reset();
    cycle();
    cycle();
    rst = 1'b1;
    busy_n = 0; done_n = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (s_busy) busy_n++;
      if (s_done) done_n++;
    end
    check("abort_no_busy", 32'(busy_n), 32'd0);
    check("abort_no_done", 32'(done_n), 32'd0);
    p0_req = 1'b1; p0_addr = 4'd9;
    cycle();
    check("abort_idle_gnt", 32'(s_g0), 32'd1);
    p0_req = 1'b0;
    cycle();

    // Randomised traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      cycle();
      if (p0_req && s_g0) p0_req = 1'b0;
      if (p1_req && s_g1) p1_req = 1'b0;
      if (!p0_req) begin
        if ($urandom_range(0, 2) == 0) begin
          p0_req = 1'b1; p0_addr = 4'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 15) == 0) begin
        p0_req = 1'b0;
      end
      if (!p1_req) begin
        if ($urandom_range(0, 2) == 0) begin
          p1_req = 1'b1; p1_we = 1'($urandom_range(0, 1));
          p1_addr = 4'($urandom_range(0, 15)); p1_wdata = 8'($urandom_range(0, 255));
        end
      end else if ($urandom_range(0, 15) == 0) begin
        p1_req = 1'b0;
      end
      clr_req = ($urandom_range(0, 63) == 0);
    end
    clr_req = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
    for (int k = 0; k < 20; k++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, synchronous-read data memory (N-bit entries, 2^M entries, write-first) between two requesters.
  - Port 0: instruction fetch, read-only.
  - Port 1: load/store, read/write.
- Round-robin arbitration when both ports request.
- Built-in clear sequencer zeroes the whole memory on command without a reset.
- Sits between the CPU pipeline front/back ends and the memory instance; it is the only driver of the memory's address, wf and w inputs.

Parameters:
- N, 32, data width of a memory entry.
- M, 16, address width; memory holds 2^M entries.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- p0_req  in  1  port 0 read request, held until granted
- p0_addr  in  M  port 0 read address
- p0_gnt  out  1  port 0 request accepted this cycle
- p0_rvalid  out  1  port 0 read data valid
- p0_rdata  out  N  port 0 read data
- p1_req  in  1  port 1 request, held until granted
- p1_we  in  1  port 1 write (1) / read (0)
- p1_addr  in  M  port 1 address
- p1_wdata  in  N  port 1 write data
- p1_gnt  out  1  port 1 request accepted this cycle
- p1_rvalid  out  1  port 1 read data valid (reads only)
- p1_rdata  out  N  port 1 read data
- clr_req  in  1  start whole-memory clear (pulse)
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse at clear completion
- mem_address  out  M  to memory address
- mem_wf  out  1  to memory write flag
- mem_w  out  N  to memory write value
- mem_v  in  N  from memory read value

Behaviour:
- States: IDLE, CLEAR.
- Reset (async, rst=0):
  - state=IDLE, rr pointer=port 0, clear counter=0.
  - p0_rvalid=p1_rvalid=0, clr_busy=0, clr_done=0.
  - Grants are 0 while rst=0.
  - Reset during CLEAR aborts it; no clr_done pulse.
- IDLE grant logic, combinational within the cycle:
  - Only one port requesting: that port is granted.
  - Both requesting: the port selected by the rr pointer is granted. On that edge the pointer moves to the other port.
  - Single-requester grants leave the pointer unchanged.
  - At most one gnt high per cycle.
  - A request is accepted at the rising edge where req&&gnt. The requester must hold addr/we/wdata stable until then. Deasserting req before grant withdraws it with no side effect.
- Memory drive:
  - Granted port 0: mem_address=p0_addr, mem_wf=0.
  - Granted port 1: mem_address=p1_addr, mem_wf=p1_we, mem_w=p1_wdata.
  - No grant: mem_address=0, mem_wf=0, mem_w=0.
- Read latency is 1 cycle.
  - Read granted in cycle t: the corresponding pxrvalid is 1 in cycle t+1 only (registered).
  - pxrdata is wired to mem_v; it is valid only while pxrvalid=1.
  - Port 1 writes: gnt is the only acknowledgement; p1_rvalid stays 0.
- Back-to-back: a port may be granted every cycle. Throughput is 1 access per cycle total.
- clr_req sampled 1 in IDLE:
  - Enter CLEAR next cycle with counter=0.
  - clr_req takes precedence over port requests in that same cycle: no grants that cycle.
- CLEAR state:
  - Each cycle: mem_address=counter, mem_wf=1, mem_w=0, counter+1.
  - No grants; requests stall, held by requesters.
  - clr_busy=1 for exactly 2^M cycles.
  - After writing address 2^M-1 (counter wraps to 0): return to IDLE and assert clr_done for one cycle.
  - Grants may resume in that same clr_done cycle.
- clr_req while in CLEAR is ignored; it does not restart the clear or extend clr_busy.
- rvalid for a read granted in the cycle where clr_req is sampled cannot occur, because no grant is issued that cycle.

Test Plan (bench uses N=8, M=4):
- Reset then single port 1 write: p1 write addr 3 data 0xA5; then p0 read addr 3. Required: p0_gnt same cycle as req, p0_rvalid next cycle, p0_rdata=0xA5.
- Simultaneous requests: p0 read addr 1 and p1 read addr 2 held 4 cycles (mem[1]=0x11, mem[2]=0x22). Required: grants alternate p0,p1,p0,p1; rvalid/rdata follow each grant by one cycle with 0x11/0x22 on the matching port.
- Write-then-read back-to-back on port 1: write addr 5 = 0x3C, then read addr 5 next cycle. Required: p1_rvalid=1 with p1_rdata=0x3C two cycles after the write grant; no rvalid for the write.
- Clear: fill all 16 entries with nonzero values, pulse clr_req with p0_req high. Required:
  - clr_busy high exactly 16 cycles; no p0_gnt during it.
  - clr_done pulses once; p0_gnt asserts in the clr_done cycle.
  - Subsequent reads of all addresses return 0.
- Clear re-trigger and abort: clr_req pulsed again at cycle 5 of CLEAR. Required: clr_busy still 16 cycles total. Separately, assert rst low at cycle 8 of CLEAR. Required: clr_busy=0 immediately, no clr_done, state IDLE after release.
- Withdrawn request: p1_req high 1 cycle while p0 holds the grant on a rr tie, then dropped. Required: no p1_gnt, no memory write, rr pointer unchanged.
